controle_multiciclo: RTL and testbench

Multicycle MIPS control FSM that sequences the shared datapath (single memory, one ALU, IR/A/B/ALUOut registers) for R-type (ADD/SUB/AND/OR/SLT), LW, SW, BEQ, ADDI and J. It sits beside the datapath and takes opcode/funct from the instruction register and `zero` from the ALU. It drives every mux select, register enable and the 3-bit ALU control. It also runs a ready/request handshake with the memory, so fetches and loads/stores may stall.

---
 rtl/controle_multiciclo_if.sv | 34 +++
 rtl/controle_multiciclo.sv | 205 ++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface controle_multiciclo_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [2:0] ula_control;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, pc_en, ula_control, illegal, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, pc_en, ula_control, illegal, state_o
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM; outputs decode from state, FETCH/MEMREAD/MEMWRITE hold until mem_ready.
// Optional BNE_EN macro adds BNE (op 000101) through the BRANCH state with inverted zero.
module controle_multiciclo (
  input  logic                    clk,
  input  logic                    rst,
  controle_multiciclo_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_legal;
  logic [2:0] w_funct_ula;
  logic       w_branch_take;

  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_src;
  logic       w_pc_en;
  logic [2:0] w_ula;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_funct_legal = 1'b1;
    w_funct_ula   = ULA_ADD;
    case (bus.funct)
      6'b100000: w_funct_ula = ULA_ADD;
      6'b100010: w_funct_ula = ULA_SUB;
      6'b100100: w_funct_ula = ULA_AND;
      6'b100101: w_funct_ula = ULA_OR;
      6'b101010: w_funct_ula = ULA_SLT;
      default:   w_funct_legal = 1'b0;
    endcase
  end

  // BNE shares the BRANCH state; only the sense of zero flips.
`ifdef BNE_EN
  assign w_branch_take = bus.zero ^ (bus.op == OP_BNE);
`else
  assign w_branch_take = bus.zero;
`endif

  always_comb begin
    w_next       = S_IDLE;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_src     = 2'b00;
    w_pc_en      = 1'b0;
    w_ula        = ULA_ADD;
    w_illegal    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ula  = 3'b000;
        w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        // IR load and PC+4 only in the completing cycle, so PC advances once per fetch.
        w_ir_write  = bus.mem_ready;
        w_pc_en     = bus.mem_ready;
        w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_funct_legal ? S_EXECUTE : S_TRAP;
          OP_BEQ:       w_next = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       w_next = S_BRANCH;
`endif
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_next    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_next      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_ula       = w_funct_ula;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_ula       = ULA_SUB;
        w_pc_src    = 2'b01;
        w_pc_en     = w_branch_take;
        w_next      = S_FETCH;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
      default: begin
        w_ula  = 3'b000;
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_write   = w_mem_write;
  assign bus.iord        = w_iord;
  assign bus.ir_write    = w_ir_write;
  assign bus.reg_write   = w_reg_write;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.pc_src      = w_pc_src;
  assign bus.pc_en       = w_pc_en;
  assign bus.ula_control = w_ula;
  assign bus.illegal     = w_illegal;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-instruction expected traces built from instruction rules.
module tb_controle_multiciclo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  controle_multiciclo_if bus ();
  controle_multiciclo dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // flag bits inside the 7-bit strobe field
  localparam logic [6:0] F_REQ = 7'h01, F_WR = 7'h02, F_IO = 7'h04, F_IRW = 7'h08;
  localparam logic [6:0] F_RW  = 7'h10, F_RD = 7'h20, F_M2R = 7'h40;

  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  logic        rdy_q[$];

  function automatic logic [20:0] ov(input logic [3:0] st, input logic [6:0] f, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] pcs, input logic pce,
                                     input logic [2:0] ula, input logic ill);
    return {st, ill, ula, pce, pcs, asb, asa, f};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.state_o, bus.illegal, bus.ula_control, bus.pc_en, bus.pc_src, bus.alu_src_b,
            bus.alu_src_a, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.ir_write, bus.iord,
            bus.mem_write, bus.mem_req};
  endfunction

  task automatic push(input logic [20:0] v, input logic r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  // Reference: cycle-by-cycle expected outputs for one instruction starting in FETCH.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input logic z);
    logic       bne;
    logic       rleg;
    logic [2:0] rula;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i <= fw; i++)
      push(ov(4'd1, F_REQ | ((i == fw) ? F_IRW : 7'h00), 1'b0, 2'b01, 2'b00, (i == fw), 3'b010, 1'b0),
           (i == fw));
    push(ov(4'd2, 7'h00, 1'b0, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0), 1'($urandom));
    rleg = 1'b1;
    case (fn)
      6'h20:   rula = 3'b010;
      6'h22:   rula = 3'b110;
      6'h24:   rula = 3'b000;
      6'h25:   rula = 3'b001;
      6'h2a:   rula = 3'b111;
      default: begin rleg = 1'b0; rula = 3'b000; end
    endcase
`ifdef BNE_EN
    bne = 1'b1;
`else
    bne = 1'b0;
`endif
    if (op == 6'h23 || op == 6'h2b) begin
      push(ov(4'd3, 7'h00, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0), 1'($urandom));
      for (int i = 0; i <= mw; i++)
        if (op == 6'h23) push(ov(4'd4, F_REQ | F_IO, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0), (i == mw));
        else push(ov(4'd6, F_REQ | F_WR | F_IO, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0), (i == mw));
      if (op == 6'h23) push(ov(4'd5, F_RW | F_M2R, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0), 1'($urandom));
    end else if (op == 6'h00 && rleg) begin
      push(ov(4'd7, 7'h00, 1'b1, 2'b00, 2'b00, 1'b0, rula, 1'b0), 1'($urandom));
      push(ov(4'd8, F_RW | F_RD, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0), 1'($urandom));
    end else if (op == 6'h04 || (op == 6'h05 && bne)) begin
      push(ov(4'd9, 7'h00, 1'b1, 2'b00, 2'b01, (op == 6'h04) ? z : !z, 3'b110, 1'b0), 1'($urandom));
    end else if (op == 6'h08) begin
      push(ov(4'd10, 7'h00, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0), 1'($urandom));
      push(ov(4'd11, F_RW, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0), 1'($urandom));
    end else if (op == 6'h02) begin
      push(ov(4'd12, 7'h00, 1'b0, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0), 1'($urandom));
    end else begin
      repeat (20) push(ov(4'd15, 7'h00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1), 1'($urandom));
      return;
    end
    // trailing FETCH with no ready: confirms the return and parks the FSM for the next instruction
    push(ov(4'd1, F_REQ, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0), 1'b0);
  endtask

  task automatic run_trace(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.op = op;
      bus.funct = fn;
      bus.zero = z;
      bus.mem_ready = rdy_q[i];
      @(negedge clk);
      obs_q.push_back(obs());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) begin
      bus.op = 6'($urandom); bus.funct = 6'($urandom);
      bus.zero = 1'($urandom); bus.mem_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'($urandom);
      @(negedge clk);
      n_chk++;
      if (obs() !== 21'h0) begin
        n_err++; $display("FAIL reset_hold%0d got=%h exp=000000", k, obs());
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (obs() !== 21'h0) begin
      n_err++; $display("FAIL reset_idle got=%h exp=000000", obs());
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if (bus.state_o !== 4'd1 || bus.mem_req !== 1'b1 || bus.ir_write !== 1'b0) begin
      n_err++; $display("FAIL reset_fetch state=%0d req=%b irw=%b exp=1,1,0", bus.state_o, bus.mem_req, bus.ir_write);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int pce_cnt;
    build(6'h00, 6'h20, 0, 0, 1'($urandom));
    run_trace(6'h00, 6'h20, 1'b0);
    pce_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
      pce_cnt += int'(obs_q[i][12]);
    end
    n_chk++;
    if (pce_cnt != 1) begin
      n_err++; $display("FAIL add_pc_en_count got=%0d exp=1", pce_cnt);
    end
  endtask

  task automatic test_lw_waits();
    int nf, nr;
    build(6'h23, 6'h00, 2, 3, 1'b0);
    run_trace(6'h23, 6'h00, 1'b0);
    nf = 0; nr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL lw cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
      if (i < exp_q.size() - 1 && obs_q[i][20:17] == 4'd1) nf++;
      if (obs_q[i][20:17] == 4'd4 && obs_q[i][2]) nr++;
    end
    n_chk++;
    if (nf != 3 || nr != 4) begin
      n_err++; $display("FAIL lw_lengths fetch=%0d memread=%0d exp=3,4", nf, nr);
    end
  endtask

  task automatic test_beq();
    for (int zz = 1; zz >= 0; zz--) begin
      build(6'h04, 6'h00, 0, 0, 1'(zz));
      run_trace(6'h04, 6'h00, 1'(zz));
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL beq z=%0d cyc%0d got=%h exp=%h", zz, i, obs_q[i], exp_q[i]);
        end
      end
      n_chk++;
      if (obs_q[2][20:17] !== 4'd9 || obs_q[2][12] !== 1'(zz) || obs_q[2][11:10] !== 2'b01) begin
        n_err++; $display("FAIL beq_branch z=%0d got=%h", zz, obs_q[2]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] fns[2];
    logic [5:0] ops[2];
    ops = '{6'h3f, 6'h00};
    fns = '{6'h20, 6'h00};
    for (int t = 0; t < 2; t++) begin
      build(ops[t], fns[t], 0, 0, 1'b0);
      run_trace(ops[t], fns[t], 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL illegal%0d cyc%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]);
        end
      end
      apply_reset();
      @(negedge clk);
      n_chk++;
      if (bus.state_o !== 4'd1 || bus.illegal !== 1'b0) begin
        n_err++; $display("FAIL illegal%0d_exit state=%0d ill=%b exp=1,0", t, bus.state_o, bus.illegal);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_bne();
    build(6'h05, 6'h00, 0, 0, 1'b0);
    run_trace(6'h05, 6'h00, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bne cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
`ifdef BNE_EN
    n_chk++;
    if (obs_q[2][20:17] !== 4'd9 || obs_q[2][12] !== 1'b1) begin
      n_err++; $display("FAIL bne_taken got=%h exp state 9 pc_en 1", obs_q[2]);
    end
`else
    n_chk++;
    if (obs_q[2][20:17] !== 4'd15) begin
      n_err++; $display("FAIL bne_trap got state=%0d exp=15", obs_q[2][20:17]);
    end
    apply_reset();
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    logic       z;
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      z  = 1'($urandom);
      build(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), z);
      run_trace(op, fn, z);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL b2b n%0d op=%h fn=%h cyc%0d got=%h exp=%h", n, op, fn, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_waits();
    test_beq();
    test_bne();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
